// File: rtl/pixel_frame_capture.sv
// Captures one OW x OW frame from a pixel stream into a RAM that the host reads in raster order.
// Latency: a pixel is readable the cycle after its write; rd_data follows rd_addr by one cycle.
// Backpressure: none. Pixels arriving in DONE are dropped and flag overflow. Optional checksum: CAPTURE_CHECKSUM_EN.
module pixel_frame_capture #(
    parameter  int W    = 5,
    localparam int OW   = W - 2,
    localparam int NPIX = OW * OW,
    localparam int AW   = $clog2(NPIX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    pixel_in,
    input  logic          pixel_valid,
    input  logic          arm,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          busy,
    output logic          done,
    output logic          frame_done,
    output logic          overflow,
    output logic [AW:0]   pix_count,
    output logic [15:0]   checksum
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [AW:0] LAST_IDX = (AW+1)'(NPIX - 1);
    localparam logic [AW:0] NPIX_CNT = (AW+1)'(NPIX);

    state_t      state_q;
    state_t      state_d;
    logic [AW:0] pix_count_q;
    logic        overflow_q;
    logic        frame_done_q;
    logic [7:0]  rd_data_q;
    logic        wr_en;
    logic        clr;
    logic        set_ovf;
    logic        last_pix;
    logic        rd_in_range;

    logic [7:0]  mem [NPIX];

    // arm always wins over a same-cycle pixel, so that pixel is never written or counted
    always_comb begin
        state_d  = state_q;
        wr_en    = 1'b0;
        clr      = 1'b0;
        set_ovf  = 1'b0;
        last_pix = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = CAPTURE;
                    clr     = 1'b1;
                end
            end
            CAPTURE: begin
                if (arm) begin
                    clr = 1'b1;
                end else if (pixel_valid) begin
                    wr_en = 1'b1;
                    if (pix_count_q == LAST_IDX) begin
                        last_pix = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (arm) begin
                    state_d = CAPTURE;
                    clr     = 1'b1;
                end else if (pixel_valid) begin
                    set_ovf = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pix_count_q  <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= last_pix;
            if (clr) begin
                pix_count_q <= '0;
                overflow_q  <= 1'b0;
            end else begin
                if (wr_en)
                    pix_count_q <= pix_count_q + 1'b1;
                if (set_ovf)
                    overflow_q <= 1'b1;
            end
        end
    end

    // RAM contents survive reset; only the read register is cleared
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[pix_count_q[AW-1:0]] <= pixel_in;
    end

    assign rd_in_range = ({1'b0, rd_addr} < NPIX_CNT);

    // Read-before-write: a same-address write this edge is not visible until the next read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data_q <= '0;
        else if (rd_in_range)
            rd_data_q <= mem[rd_addr];
        else
            rd_data_q <= '0;
    end

`ifdef CAPTURE_CHECKSUM_EN
    logic [15:0] checksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            checksum_q <= '0;
        else if (clr)
            checksum_q <= '0;
        else if (wr_en)
            checksum_q <= checksum_q + {8'd0, pixel_in};
    end

    assign checksum = checksum_q;
`else
    assign checksum = 16'd0;
`endif

    assign busy       = (state_q == CAPTURE);
    assign done       = (state_q == DONE);
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign pix_count  = pix_count_q;
    assign rd_data    = rd_data_q;

endmodule

// File: doc/pixel_frame_capture.md
PIXEL_FRAME_CAPTURE -- requirements
Module: pixel_frame_capture

Interface
REQ-001 SHALL have parameter W, default 5: input image width; output frame is OW x OW with OW = W-2.
REQ-002 SHALL have derived localparams NPIX = OW*OW (default 9) and AW = clog2(NPIX) (default 4).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port pixel_in, input, 8 bits: stream pixel from the conv engine output.
REQ-006 SHALL have port pixel_valid, input, 1 bit: pixel_in is valid this cycle; no backpressure.
REQ-007 SHALL have port arm, input, 1 bit: one-cycle request to start or restart a capture.
REQ-008 SHALL have port rd_addr, input, AW bits: host read address, raster order.
REQ-009 SHALL have port rd_data, output, 8 bits: captured pixel at rd_addr.
REQ-010 SHALL have port busy, output, 1 bit: state is CAPTURE.
REQ-011 SHALL have port done, output, 1 bit: state is DONE.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse on the cycle DONE is entered.
REQ-013 SHALL have port overflow, output, 1 bit: sticky; a valid pixel arrived while in DONE.
REQ-014 SHALL have port pix_count, output, AW+1 bits: pixels written in the current capture.
REQ-015 SHALL have port checksum, output, 16 bits: running sum of captured pixels (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, CAPTURE and DONE.
REQ-017 SHALL in IDLE ignore pixel_valid; arm moves to CAPTURE and clears pix_count, checksum and overflow.
REQ-018 SHALL in CAPTURE, per pixel_valid cycle, write pixel_in to mem[pix_count] and increment pix_count.
REQ-019 SHALL, on the valid pixel that makes pix_count reach NPIX, move to DONE and assert frame_done on the following cycle only.
REQ-020 SHALL in DONE discard valid pixels and set overflow; pix_count holds at NPIX; memory is unchanged.
REQ-021 SHALL treat arm in CAPTURE or DONE as a restart: go to CAPTURE, clear pix_count, checksum and overflow.
REQ-022 SHALL give arm priority over pixel_valid in the same cycle; that pixel is discarded and not counted.
REQ-023 SHALL provide a synchronous read with rd_data = mem[rd_addr sampled on the previous edge], valid in every state.
REQ-024 SHALL return the old memory content on rd_data when a read and a write hit the same address in the same cycle.
REQ-025 SHALL return undefined-but-stable data for rd_addr >= NPIX, with no side effects.
REQ-026 SHALL accept back-to-back pixel_valid at full clock rate, as well as gapped pixel_valid.
REQ-027 SHALL compute checksum as a 16-bit sum of zero-extended pixels that wraps modulo 2^16.

Reset
REQ-028 SHALL on rst_n low immediately set the state to IDLE and set busy, done, frame_done, overflow, pix_count, checksum and rd_data to 0.
REQ-029 SHALL not clear memory contents on reset.
REQ-030 SHALL abandon a capture that reset interrupts; after reset deasserts, an arm is required before any pixel is captured.

Configuration
REQ-031 SHALL, with macro CAPTURE_CHECKSUM_EN defined, implement the checksum accumulator as specified.
REQ-032 SHALL, without CAPTURE_CHECKSUM_EN, tie checksum to 0 and implement no accumulator logic.

Verification
REQ-033 SHALL cover normal capture: reset, arm, then 9 back-to-back pixels 10,20,...,90 -> frame_done pulses once, done=1, pix_count=9, reads 0..8 return 10..90, checksum=450 (CAPTURE_CHECKSUM_EN).
REQ-034 SHALL cover overflow: after the capture above, 2 further valid pixels of 255 -> overflow=1, mem[8] still 90, pix_count=9.
REQ-035 SHALL cover restart with a collision: arm mid-frame after 4 pixels, with pixel_valid high on the arm cycle -> pix_count=0, that pixel is not stored, and the next 9 pixels fill addresses 0..8.
REQ-036 SHALL cover gapped input: 9 pixels with pixel_valid toggling every other cycle -> same result as REQ-033, with frame_done one cycle after the 9th pixel.
REQ-037 SHALL cover reset mid-capture: rst_n low after 5 pixels -> all outputs 0 asynchronously; pixels arriving after release are ignored until arm.
REQ-038 SHALL cover the build without CAPTURE_CHECKSUM_EN: rerun REQ-033 -> checksum=0, all other results identical.
